cell_run_ctrl: RTL and testbench

Run/fault sequencer for one H-bridge power cell. It sits between the cell command interface and the dead-time/PWM output stage, and gates that stage through `start`, `chkflt` and `fault`. On a run request it performs the IGBT driver fault-check sequence, then arms and enables switching. It latches any driver or DC-bus fault into a coded register that is cleared by explicit handshake.

---
 rtl/cell_run_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cell_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cell_run_ctrl.sv
// Run/fault sequencer for one H-bridge power cell.
// Runs the IGBT driver fault-check, arms and enables switching, and latches
// driver / DC-bus / check-timeout faults into a coded register that is only
// cleared by an explicit clear handshake.
module cell_run_ctrl #(
    parameter logic [16:0] CHK_TMO  = 17'd70000,
    parameter logic [16:0] ARM_DLY  = 17'd1000,
    parameter logic [16:0] STOP_DLY = 17'd480
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run_req,
    input  logic       flt_clr,
    input  logic       dc_ok,
    input  logic [3:0] igbt_flt,
    input  logic       chkflt_over,
    output logic       start,
    output logic       chkflt,
    output logic       fault,
    output logic [5:0] flt_code,
    output logic [2:0] state,
    output logic       run_ok
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StArm   = 3'd2,
        StRun   = 3'd3,
        StStop  = 3'd4,
        StFault = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [5:0]  flt_code_q, flt_code_d;
    logic        start_q, start_d;
    logic        chkflt_q, chkflt_d;
    logic        fault_q, fault_d;
    logic        run_ok_q, run_ok_d;

    logic [3:0]  igbt_s1, igbt_s2;
    logic        dc_s1, dc_s2;

    // Run-time fault bits as they would be OR-ed into flt_code.
    logic [5:0]  rt_flt;
    logic        rt_flt_any;

    assign rt_flt     = {1'b0, ~dc_s2, igbt_s2};
    assign rt_flt_any = |rt_flt;

    // Two-flop synchronisers for the asynchronous fault/bus inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            igbt_s1 <= 4'd0;
            igbt_s2 <= 4'd0;
            dc_s1   <= 1'b0;
            dc_s2   <= 1'b0;
        end else begin
            igbt_s1 <= igbt_flt;
            igbt_s2 <= igbt_s1;
            dc_s1   <= dc_ok;
            dc_s2   <= dc_s1;
        end
    end

    // State, counter, fault code and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= 17'd0;
            flt_code_q <= 6'd0;
            start_q    <= 1'b0;
            chkflt_q   <= 1'b0;
            fault_q    <= 1'b0;
            run_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flt_code_q <= flt_code_d;
            start_q    <= start_d;
            chkflt_q   <= chkflt_d;
            fault_q    <= fault_d;
            run_ok_q   <= run_ok_d;
        end
    end

    // Next-state, fault-code accumulation and cycle counter.
    always_comb begin
        state_d    = state_q;
        flt_code_d = flt_code_q;
        case (state_q)
            StIdle: begin
                if (run_req && dc_s2 && (flt_code_q == 6'd0)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Driver fault pulses are part of the check itself; only
                // sample them when the output stage reports completion.
                if (!run_req) begin
                    state_d = StIdle;
                end else if (!dc_s2) begin
                    state_d    = StFault;
                    flt_code_d = flt_code_q | 6'h10;
                end else if (cnt_q == CHK_TMO) begin
                    state_d    = StFault;
                    flt_code_d = flt_code_q | 6'h20;
                end else if (chkflt_over && (cnt_q >= 17'd2)) begin
                    if (igbt_s2 != 4'd0) begin
                        state_d    = StFault;
                        flt_code_d = flt_code_q | {2'b00, igbt_s2};
                    end else begin
                        state_d = StArm;
                    end
                end
            end
            StArm: begin
                if (!run_req) begin
                    state_d = StIdle;
                end else if (rt_flt_any) begin
                    state_d    = StFault;
                    flt_code_d = flt_code_q | rt_flt;
                end else if (cnt_q == ARM_DLY - 17'd1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A fault beats a simultaneous stop request.
                if (rt_flt_any) begin
                    state_d    = StFault;
                    flt_code_d = flt_code_q | rt_flt;
                end else if (!run_req) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (rt_flt_any) begin
                    state_d    = StFault;
                    flt_code_d = flt_code_q | rt_flt;
                end else if (cnt_q == STOP_DLY - 17'd1) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                // A new fault bit in the clear cycle blocks the clear.
                if (flt_clr && !run_req && !rt_flt_any) begin
                    state_d    = StIdle;
                    flt_code_d = 6'd0;
                end else begin
                    flt_code_d = flt_code_q | rt_flt;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 17'd0;
        end else if (((state_q == StCheck) || (state_q == StArm) || (state_q == StStop))
                     && (cnt_q != 17'h1FFFF)) begin
            cnt_d = cnt_q + 17'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from the next state so outputs change with the state.
    always_comb begin
        start_d  = (state_d == StRun);
        run_ok_d = (state_d == StRun);
        chkflt_d = (state_d == StCheck);
        fault_d  = (flt_code_d != 6'd0);
    end

    assign start    = start_q;
    assign chkflt   = chkflt_q;
    assign fault    = fault_q;
    assign flt_code = flt_code_q;
    assign state    = state_q;
    assign run_ok   = run_ok_q;

endmodule

// File: tb/tb_cell_run_ctrl.sv
// Directed bench for cell_run_ctrl with shortened delays (check timeout 700,
// arm delay 100, stop hold 48) so every sequence fits in a short run.
module tb_cell_run_ctrl;

    logic       clk;
    logic       rstn;
    logic       run_req;
    logic       flt_clr;
    logic       dc_ok;
    logic [3:0] igbt_flt;
    logic       chkflt_over;
    logic       start;
    logic       chkflt;
    logic       fault;
    logic [5:0] flt_code;
    logic [2:0] state;
    logic       run_ok;

    int errors = 0;
    int checks = 0;

    cell_run_ctrl #(
        .CHK_TMO  (17'd700),
        .ARM_DLY  (17'd100),
        .STOP_DLY (17'd48)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run_req     (run_req),
        .flt_clr     (flt_clr),
        .dc_ok       (dc_ok),
        .igbt_flt    (igbt_flt),
        .chkflt_over (chkflt_over),
        .start       (start),
        .chkflt      (chkflt),
        .fault       (fault),
        .flt_code    (flt_code),
        .state       (state),
        .run_ok      (run_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; run_req = 1'b0; flt_clr = 1'b0; dc_ok = 1'b0;
        igbt_flt = 4'd0; chkflt_over = 1'b0;
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_chkflt", 32'(chkflt), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_code", 32'(flt_code), 32'd0);
        chk("rst_run_ok", 32'(run_ok), 32'd0);
        rstn = 1'b1;

        // Normal start
        dc_ok = 1'b1;
        tick(3);
        run_req = 1'b1;
        tick(1);
        chk("chk_enter_state", 32'(state), 32'd1);
        chk("chk_enter_chkflt", 32'(chkflt), 32'd1);
        // Stale completion flag at counter 0 and 1 must be ignored
        chkflt_over = 1'b1;
        tick(2);
        chkflt_over = 1'b0;
        chk("stale_over_ignored", 32'(state), 32'd1);
        tick(638);
        chk("chk_at_640", 32'(chkflt), 32'd1);
        chkflt_over = 1'b1;
        tick(1);
        chkflt_over = 1'b0;
        chk("arm_state", 32'(state), 32'd2);
        chk("arm_chkflt", 32'(chkflt), 32'd0);
        chk("arm_start", 32'(start), 32'd0);
        tick(99);
        chk("arm_99", 32'(state), 32'd2);
        tick(1);
        chk("run_state", 32'(state), 32'd3);
        chk("run_start", 32'(start), 32'd1);
        chk("run_ok", 32'(run_ok), 32'd1);

        // Stop
        run_req = 1'b0;
        tick(1);
        chk("stop_state", 32'(state), 32'd4);
        chk("stop_start", 32'(start), 32'd0);
        chk("stop_run_ok", 32'(run_ok), 32'd0);
        tick(47);
        chk("stop_47", 32'(state), 32'd4);
        tick(1);
        chk("stop_to_idle", 32'(state), 32'd0);
        chk("stop_no_fault", 32'(fault), 32'd0);

        // Run-time IGBT fault, coincident with a stop request
        run_req = 1'b1; chkflt_over = 1'b1;
        tick(4);
        chkflt_over = 1'b0;
        chk("rerun_arm", 32'(state), 32'd2);
        tick(100);
        chk("rerun_run", 32'(state), 32'd3);
        igbt_flt = 4'b0100;
        tick(2);
        chk("igbt_latency_state", 32'(state), 32'd3);
        chk("igbt_latency_start", 32'(start), 32'd1);
        run_req = 1'b0;
        tick(1);
        chk("igbt_fault_state", 32'(state), 32'd5);
        chk("igbt_fault_start", 32'(start), 32'd0);
        chk("igbt_fault_flag", 32'(fault), 32'd1);
        chk("igbt_fault_code", 32'(flt_code), 32'h04);
        igbt_flt = 4'd0; run_req = 1'b1;
        tick(3);
        flt_clr = 1'b1;
        tick(1);
        flt_clr = 1'b0;
        chk("clr_with_run_ignored", 32'(state), 32'd5);
        chk("clr_with_run_code", 32'(flt_code), 32'h04);

        // DC loss accumulates; clear blocked while bus is down
        dc_ok = 1'b0;
        tick(3);
        chk("dc_accum_code", 32'(flt_code), 32'h14);
        run_req = 1'b0; flt_clr = 1'b1;
        tick(1);
        flt_clr = 1'b0;
        chk("clr_dc_low_blocked", 32'(state), 32'd5);
        dc_ok = 1'b1;
        tick(3);
        flt_clr = 1'b1;
        tick(1);
        flt_clr = 1'b0;
        chk("clr_ok_state", 32'(state), 32'd0);
        chk("clr_ok_code", 32'(flt_code), 32'd0);
        chk("clr_ok_fault", 32'(fault), 32'd0);

        // Check failure: IGBT fault present at completion
        run_req = 1'b1; igbt_flt = 4'b0010; chkflt_over = 1'b1;
        tick(1);
        chk("chkfail_enter", 32'(state), 32'd1);
        tick(3);
        chk("chkfail_state", 32'(state), 32'd5);
        chk("chkfail_code", 32'(flt_code), 32'h02);
        chk("chkfail_chkflt", 32'(chkflt), 32'd0);
        run_req = 1'b0; igbt_flt = 4'd0; chkflt_over = 1'b0;
        tick(3);
        flt_clr = 1'b1;
        tick(1);
        flt_clr = 1'b0;
        chk("chkfail_cleared", 32'(state), 32'd0);

        // Check timeout
        run_req = 1'b1;
        tick(1);
        chk("tmo_enter", 32'(state), 32'd1);
        tick(700);
        chk("tmo_700_still_check", 32'(state), 32'd1);
        tick(1);
        chk("tmo_state", 32'(state), 32'd5);
        chk("tmo_code", 32'(flt_code), 32'h20);
        run_req = 1'b0;
        tick(1);
        flt_clr = 1'b1;
        tick(1);
        flt_clr = 1'b0;
        chk("tmo_cleared", 32'(flt_code), 32'd0);

        // Abort mid-check
        run_req = 1'b1;
        tick(11);
        chk("abort_in_check", 32'(state), 32'd1);
        run_req = 1'b0;
        tick(1);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_chkflt", 32'(chkflt), 32'd0);
        chk("abort_fault", 32'(fault), 32'd0);

        // Asynchronous reset mid-run
        run_req = 1'b1; chkflt_over = 1'b1;
        tick(4);
        chkflt_over = 1'b0;
        tick(100);
        chk("rst_run_pre", 32'(start), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_rst_start", 32'(start), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_run_ok", 32'(run_ok), 32'd0);
        chk("async_rst_code", 32'(flt_code), 32'd0);
        tick(2);
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
